// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : layer_compositor
// Description : Merges NUM_LAYERS layer pixel streams into one RGB output.
//               A three-stage pipeline:
//                 S1 registers the inputs,
//                 S2 selects the winning and underlying layer,
//                 S3 applies blending and blanking.
//               Sync signals travel the same pipeline. Per-frame collision
//               flags are latched on each vsync rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int CHAN_BITS  = 4
) (
  input  logic                                             clkPixel,
  input  logic                                             reset,
  input  logic [NUM_LAYERS*3*CHAN_BITS-1:0]                layerRgb,
  input  logic [NUM_LAYERS-1:0]                            layerOpaque,
  input  logic [NUM_LAYERS-1:0]                            layersVisible,
  input  logic [NUM_LAYERS-1:0]                            blendMask,
  input  logic [3*CHAN_BITS-1:0]                           backdrop,
  input  logic                                             hsyncIn,
  input  logic                                             vsyncIn,
  input  logic                                             videoActiveIn,
  output logic [CHAN_BITS-1:0]                             red,
  output logic [CHAN_BITS-1:0]                             green,
  output logic [CHAN_BITS-1:0]                             blue,
  output logic                                             hsync,
  output logic                                             vsync,
  output logic                                             videoActive,
  output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] topLayer,
  output logic [NUM_LAYERS-1:0]                            collisionFlags
);

  localparam int PIX_W = 3 * CHAN_BITS;
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  // Index reported when the backdrop wins.
  localparam logic [IDX_W-1:0] IDX_NONE = '1;

  // --------------------------------------------------------------------------
  // Stage 1: input registers
  // --------------------------------------------------------------------------
  logic [NUM_LAYERS*PIX_W-1:0] rgb1_q;
  logic [NUM_LAYERS-1:0]       eff1_q;
  logic [NUM_LAYERS-1:0]       blend1_q;
  logic [PIX_W-1:0]            backdrop1_q;
  logic                        hs1_q;
  logic                        vs1_q;
  logic                        va1_q;

  // Capture every input.
  // A layer only takes part when it is both opaque and enabled.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      rgb1_q      <= '0;
      eff1_q      <= '0;
      blend1_q    <= '0;
      backdrop1_q <= '0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      va1_q       <= 1'b0;
    end else begin
      rgb1_q      <= layerRgb;
      eff1_q      <= layerOpaque & layersVisible;
      blend1_q    <= blendMask;
      backdrop1_q <= backdrop;
      hs1_q       <= hsyncIn;
      vs1_q       <= vsyncIn;
      va1_q       <= videoActiveIn;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: priority select and collision detection
  // --------------------------------------------------------------------------
  logic [PIX_W-1:0]      top_d;
  logic [PIX_W-1:0]      under_d;
  logic [IDX_W-1:0]      win_d;
  logic                  doBlend_d;
  logic [NUM_LAYERS-1:0] hits_d;
  logic                  frameEdge_d;

  logic [PIX_W-1:0]      top2_q;
  logic [PIX_W-1:0]      under2_q;
  logic [IDX_W-1:0]      win2_q;
  logic                  blend2_q;
  logic                  hs2_q;
  logic                  vs2_q;
  logic                  va2_q;

  logic [NUM_LAYERS-1:0] acc_q;
  logic [NUM_LAYERS-1:0] acc_d;
  logic [NUM_LAYERS-1:0] flags_q;
  logic [NUM_LAYERS-1:0] flags_d;

  // Ascending scan: each newly found layer demotes the previous winner to "under".
  // The backdrop therefore ends up as "under" when nothing lies beneath the winner.
  always_comb begin
    top_d     = backdrop1_q;
    under_d   = backdrop1_q;
    win_d     = IDX_NONE;
    doBlend_d = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (eff1_q[i]) begin
        under_d   = top_d;
        top_d     = rgb1_q[i*PIX_W +: PIX_W];
        win_d     = IDX_W'(i);
        doBlend_d = blend1_q[i];
      end
    end
  end

  // A present layer is hit when any higher layer is present on an active pixel.
  // The topmost layer can never be hit.
  always_comb begin
    logic above;
    hits_d = '0;
    above  = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      hits_d[i] = eff1_q[i] & above & va1_q;
      above     = above | eff1_q[i];
    end
  end

  // A frame boundary is the rising edge of vsync as it leaves stage 1.
  assign frameEdge_d = vs1_q & ~vs2_q;

  // Accumulate hits through the frame.
  // At the boundary, publish them (including this cycle's hits) and restart empty.
  always_comb begin
    acc_d   = acc_q | hits_d;
    flags_d = flags_q;
    if (frameEdge_d) begin
      flags_d = acc_q | hits_d;
      acc_d   = '0;
    end
  end

  // Stage 2 registers: the selected colours and winner, with sync delayed another stage.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      top2_q   <= '0;
      under2_q <= '0;
      win2_q   <= IDX_NONE;
      blend2_q <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      va2_q    <= 1'b0;
    end else begin
      top2_q   <= top_d;
      under2_q <= under_d;
      win2_q   <= win_d;
      blend2_q <= doBlend_d;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      va2_q    <= va1_q;
    end
  end

  // Collision accumulator and the per-frame flag latch.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: blend, blank and output registers
  // --------------------------------------------------------------------------
  logic [PIX_W-1:0] mix_d;
  logic [PIX_W-1:0] pix_d;

  logic [PIX_W-1:0] pix3_q;
  logic [IDX_W-1:0] top3_q;
  logic             hs3_q;
  logic             vs3_q;
  logic             va3_q;

  // Each channel averages in CHAN_BITS+1 bits.
  // Dropping the LSB rounds the result down.
  genvar c;
  generate
    for (c = 0; c < 3; c++) begin : g_chan
      logic [CHAN_BITS:0] sum;
      assign sum = {1'b0, top2_q[c*CHAN_BITS +: CHAN_BITS]}
                 + {1'b0, under2_q[c*CHAN_BITS +: CHAN_BITS]};
      assign mix_d[c*CHAN_BITS +: CHAN_BITS] =
        blend2_q ? sum[CHAN_BITS:1] : top2_q[c*CHAN_BITS +: CHAN_BITS];
    end
  endgenerate

  // Colour is forced black outside the active area.
  // The layer index and sync signals still pass through.
  assign pix_d = va2_q ? mix_d : '0;

  // Output registers.
  // Reset shows black with the "backdrop" index, so the pins are clean while in reset.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      pix3_q <= '0;
      top3_q <= IDX_NONE;
      hs3_q  <= 1'b0;
      vs3_q  <= 1'b0;
      va3_q  <= 1'b0;
    end else begin
      pix3_q <= pix_d;
      top3_q <= win2_q;
      hs3_q  <= hs2_q;
      vs3_q  <= vs2_q;
      va3_q  <= va2_q;
    end
  end

  assign red            = pix3_q[2*CHAN_BITS +: CHAN_BITS];
  assign green          = pix3_q[CHAN_BITS +: CHAN_BITS];
  assign blue           = pix3_q[0 +: CHAN_BITS];
  assign hsync          = hs3_q;
  assign vsync          = vs3_q;
  assign videoActive    = va3_q;
  assign topLayer       = top3_q;
  assign collisionFlags = flags_q;

endmodule
`default_nettype wire
